parking_gate_controller: RTL
============================

PARKING_GATE_CONTROLLER -- requirements
Module: parking_gate_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, consecutive stable samples required to accept a sensor level change (range 2..255).
REQ-002 Parameter GATE_TIMEOUT, default 1000, cycles a gate may stay open without a pass before abort (range 2..65535).
REQ-003 clk  in  1  single system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 entry_sensor  in  1  raw vehicle-present loop at entry gate.
REQ-006 entry_uni_badge  in  1  raw level; 1 = university badge read at entry.
REQ-007 entry_passed  in  1  raw beam behind entry gate; 1 = vehicle through.
REQ-008 exit_sensor / exit_uni_badge / exit_passed  in  1 each  exit-gate equivalents.
REQ-009 uni_is_vacated_space, is_vacated_space  in  1 each  space-available flags from the downstream parking_management_system.
REQ-010 entry_gate_open, exit_gate_open  out  1 each  barrier open commands.
REQ-011 car_entered, is_uni_car_entered, car_exited, is_uni_car_exited  out  1 each  event pulses to the downstream counter.
REQ-012 entry_denied  out  1  one-cycle pulse on refused entry.

Function
REQ-013 Each of entry_sensor, entry_passed, exit_sensor, exit_passed SHALL be debounced: output changes at the edge sampling the DEBOUNCE_CYCLES-th consecutive sample differing from current output; any agreeing sample restarts the count.
REQ-014 Badges SHALL be sampled raw (2-flop synchronised) and latched when the gate FSM leaves IDLE.
REQ-015 Entry FSM states: IDLE, CHECK, OPEN, COMMIT, DENY, WAIT_CLEAR.
REQ-016 IDLE->CHECK on debounced entry_sensor rising; latch uni flag.
REQ-017 CHECK (1 cycle): uni flag ? uni_is_vacated_space : is_vacated_space; 1 -> OPEN, 0 -> DENY.
REQ-018 OPEN: entry_gate_open=1; debounced entry_passed=1 -> COMMIT.
REQ-019 COMMIT: car_entered=1 and is_uni_car_entered=latched flag for exactly one cycle, gate closes, -> WAIT_CLEAR.
REQ-020 DENY: entry_denied=1 one cycle, gate stays closed, -> WAIT_CLEAR.
REQ-021 WAIT_CLEAR -> IDLE when debounced entry_sensor and entry_passed both 0.
REQ-022 Exit FSM: identical states minus CHECK/DENY; IDLE->OPEN directly; COMMIT drives car_exited/is_uni_car_exited.
REQ-023 is_uni_* outputs SHALL be 0 whenever the corresponding event pulse is 0.
REQ-024 Simultaneous COMMIT: exit pulse issued first; entry FSM holds COMMIT one extra cycle; the two pulses never share a cycle.
REQ-025 Space flags change while OPEN SHALL NOT close an already-open gate.
REQ-026 At most one pulse per vehicle; a sensor that bounces after commit SHALL NOT produce a second pulse before WAIT_CLEAR completes.

Reset
REQ-027 reset=1 at an edge forces both FSMs to IDLE, debounce outputs and counters to 0, all outputs to 0 from the next cycle, regardless of state (mid-open gate closes, no pulse emitted).
REQ-028 After reset release, an already-high sensor requires full DEBOUNCE_CYCLES before acceptance.

Configuration
REQ-029 Macro GATE_TIMEOUT_EN defined: a per-gate counter runs in OPEN; reaching GATE_TIMEOUT cycles without a pass -> WAIT_CLEAR, gate closes, no event pulse.
REQ-030 GATE_TIMEOUT_EN undefined: no timeout counter; OPEN persists until pass or reset.

Structure
REQ-031 Package parking_pkg SHALL hold the gate FSM state encoding and default DEBOUNCE_CYCLES/GATE_TIMEOUT constants.
REQ-032 Debounce SHALL be sub-module sensor_debounce (param DEBOUNCE_CYCLES), instantiated four times.

Verification (DEBOUNCE_CYCLES=4, GATE_TIMEOUT=20)
REQ-033 Uni entry, uni_is_vacated_space=1: sensor high, badge=1, passed high 6 cycles -> gate opens, exactly one car_entered with is_uni_car_entered=1.
REQ-034 Non-uni entry, is_vacated_space=0 -> entry_denied one cycle, gate never opens, no car_entered.
REQ-035 Sensor glitch high 3 cycles -> no state change, no outputs.
REQ-036 Entry and exit passes debounced same cycle -> car_exited at cycle n, car_entered at n+1.
REQ-037 GATE_TIMEOUT_EN, no pass -> gate closes 20 cycles after opening, no pulse; without macro gate stays open 100+ cycles.
REQ-038 reset asserted while entry gate open -> all outputs 0 next cycle, no car_entered.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared gate FSM encoding and default timing constants for the parking gate controller.
package parking_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 4;
    localparam int unsigned GATE_TIMEOUT_DEFAULT    = 1000;

    typedef enum logic [2:0] {
        GATE_IDLE,
        GATE_CHECK,
        GATE_OPEN,
        GATE_COMMIT,
        GATE_DENY,
        GATE_WAIT_CLEAR
    } gate_state_t;

endpackage

// File: rtl/sensor_debounce.sv
// Level debouncer: the output follows the input only after DEBOUNCE_CYCLES consecutive differing samples.
module sensor_debounce
    import parking_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level
);

    logic       level_reg;
    logic [7:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_reg <= 1'b0;
            count_reg <= 8'd0;
        end else if (raw != level_reg) begin
            // The sample being taken now is the last one needed, so flip on this edge.
            if (count_reg == 8'(DEBOUNCE_CYCLES - 1)) begin
                level_reg <= raw;
                count_reg <= 8'd0;
            end else begin
                count_reg <= count_reg + 8'd1;
            end
        end else begin
            count_reg <= 8'd0;
        end
    end

    assign level = level_reg;

endmodule

// File: rtl/parking_gate_controller.sv
// Entry/exit barrier controller with debounced loops and badge-qualified admission.
// Optional open-gate abort timer is compiled in with the GATE_TIMEOUT_EN macro.
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned GATE_TIMEOUT    = GATE_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic entry_sensor,
    input  logic entry_uni_badge,
    input  logic entry_passed,
    input  logic exit_sensor,
    input  logic exit_uni_badge,
    input  logic exit_passed,
    input  logic uni_is_vacated_space,
    input  logic is_vacated_space,
    output logic entry_gate_open,
    output logic exit_gate_open,
    output logic car_entered,
    output logic is_uni_car_entered,
    output logic car_exited,
    output logic is_uni_car_exited,
    output logic entry_denied
);

    // Bit order: 0 entry_sensor, 1 entry_passed, 2 exit_sensor, 3 exit_passed.
    logic [3:0] raw_vec;
    logic [3:0] db_vec;

    assign raw_vec = {exit_passed, exit_sensor, entry_passed, entry_sensor};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
            sensor_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk  (clk),
                .reset(reset),
                .raw  (raw_vec[gi]),
                .level(db_vec[gi])
            );
        end
    endgenerate

    logic [1:0]  badge_meta_reg, badge_sync_reg, sensor_prev_reg;
    logic        entry_rise, exit_rise;
    gate_state_t entry_state_reg, entry_state_next;
    gate_state_t exit_state_reg, exit_state_next;
    logic        entry_uni_reg, entry_uni_next;
    logic        exit_uni_reg, exit_uni_next;
    logic        entry_timeout, exit_timeout;

    assign entry_rise = db_vec[0] & ~sensor_prev_reg[0];
    assign exit_rise  = db_vec[2] & ~sensor_prev_reg[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            badge_meta_reg  <= 2'b00;
            badge_sync_reg  <= 2'b00;
            sensor_prev_reg <= 2'b00;
            entry_state_reg <= GATE_IDLE;
            exit_state_reg  <= GATE_IDLE;
            entry_uni_reg   <= 1'b0;
            exit_uni_reg    <= 1'b0;
        end else begin
            badge_meta_reg  <= {exit_uni_badge, entry_uni_badge};
            badge_sync_reg  <= badge_meta_reg;
            sensor_prev_reg <= {db_vec[2], db_vec[0]};
            entry_state_reg <= entry_state_next;
            exit_state_reg  <= exit_state_next;
            entry_uni_reg   <= entry_uni_next;
            exit_uni_reg    <= exit_uni_next;
        end
    end

`ifdef GATE_TIMEOUT_EN
    logic [15:0] entry_timer_reg, exit_timer_reg;

    always_ff @(posedge clk) begin
        if (reset || entry_state_reg != GATE_OPEN) entry_timer_reg <= 16'd0;
        else                                       entry_timer_reg <= entry_timer_reg + 16'd1;
        if (reset || exit_state_reg != GATE_OPEN)  exit_timer_reg  <= 16'd0;
        else                                       exit_timer_reg  <= exit_timer_reg + 16'd1;
    end

    assign entry_timeout = (entry_timer_reg == 16'(GATE_TIMEOUT - 1));
    assign exit_timeout  = (exit_timer_reg == 16'(GATE_TIMEOUT - 1));
`else
    // Timeout compiled out; a zero timeout cannot occur in the legal parameter range.
    assign entry_timeout = (GATE_TIMEOUT == 0);
    assign exit_timeout  = (GATE_TIMEOUT == 0);
`endif

    always_comb begin
        entry_state_next   = entry_state_reg;
        entry_uni_next     = entry_uni_reg;
        entry_gate_open    = 1'b0;
        car_entered        = 1'b0;
        is_uni_car_entered = 1'b0;
        entry_denied       = 1'b0;
        case (entry_state_reg)
            GATE_IDLE: begin
                if (entry_rise) begin
                    entry_state_next = GATE_CHECK;
                    entry_uni_next   = badge_sync_reg[0];
                end
            end
            GATE_CHECK: begin
                if (entry_uni_reg ? uni_is_vacated_space : is_vacated_space)
                    entry_state_next = GATE_OPEN;
                else
                    entry_state_next = GATE_DENY;
            end
            GATE_OPEN: begin
                entry_gate_open = 1'b1;
                if (db_vec[1])          entry_state_next = GATE_COMMIT;
                else if (entry_timeout) entry_state_next = GATE_WAIT_CLEAR;
            end
            GATE_COMMIT: begin
                // Yield to a coinciding exit commit so the counter never sees two pulses at once.
                if (exit_state_reg != GATE_COMMIT) begin
                    car_entered        = 1'b1;
                    is_uni_car_entered = entry_uni_reg;
                    entry_state_next   = GATE_WAIT_CLEAR;
                end
            end
            GATE_DENY: begin
                entry_denied     = 1'b1;
                entry_state_next = GATE_WAIT_CLEAR;
            end
            GATE_WAIT_CLEAR: begin
                if (!db_vec[0] && !db_vec[1]) entry_state_next = GATE_IDLE;
            end
            default: entry_state_next = GATE_IDLE;
        endcase
    end

    always_comb begin
        exit_state_next   = exit_state_reg;
        exit_uni_next     = exit_uni_reg;
        exit_gate_open    = 1'b0;
        car_exited        = 1'b0;
        is_uni_car_exited = 1'b0;
        case (exit_state_reg)
            GATE_IDLE: begin
                if (exit_rise) begin
                    exit_state_next = GATE_OPEN;
                    exit_uni_next   = badge_sync_reg[1];
                end
            end
            GATE_OPEN: begin
                exit_gate_open = 1'b1;
                if (db_vec[3])         exit_state_next = GATE_COMMIT;
                else if (exit_timeout) exit_state_next = GATE_WAIT_CLEAR;
            end
            GATE_COMMIT: begin
                car_exited        = 1'b1;
                is_uni_car_exited = exit_uni_reg;
                exit_state_next   = GATE_WAIT_CLEAR;
            end
            GATE_WAIT_CLEAR: begin
                if (!db_vec[2] && !db_vec[3]) exit_state_next = GATE_IDLE;
            end
            default: exit_state_next = GATE_IDLE;
        endcase
    end

endmodule
